// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: synchronous FIFO controller wrapped around a dual-port SRAM.
// SRAM port 1 is write-only (push side) and port 0 is read-only (pop side).
// The controller owns the pointers and the full/empty logic, plus a 2-entry output
// buffer. The buffer hides the 1-cycle SRAM read latency so that one pop per cycle
// can be sustained.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   flush_i               synchronous clear of all contents (wins over push/pop/issue)
//   wdata_i/wvalid_i/     push handshake
//     wready_o
//   rdata_o/rvalid_o/     pop handshake (head of the output buffer)
//     rready_i
//   count_o               total entries held (SRAM + in-flight read + output buffer)
//   ram_*0                SRAM port 0 (read only; data valid one cycle after enable)
//   ram_*1                SRAM port 1 (write only)
module sram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned AW         = $clog2(DATA_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic                              wvalid_i,
    output logic                              wready_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              rvalid_o,
    input  logic                              rready_i,
    output logic [$clog2(DATA_DEPTH+3)-1:0]   count_o,
    output logic                              ram_en0_o,
    output logic [AW-1:0]                     ram_addr0_o,
    output logic                              ram_we0_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata0_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata0_i,
    output logic                              ram_en1_o,
    output logic [AW-1:0]                     ram_addr1_o,
    output logic                              ram_we1_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata1_o
);

    localparam int unsigned CW       = $clog2(DATA_DEPTH + 3);
    localparam logic [AW:0] DepthVal = DATA_DEPTH[AW:0];

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_count_q, ob_count_d;
    logic                  ob_head_q, ob_head_d;
    logic [DATA_WIDTH-1:0] ob_mem_q [2];
    logic [CW-1:0]         count_q, count_d;

    logic [AW:0] sram_fill;
    logic        push, pop_req, pop, issue, ob_push;

    always_comb begin
        sram_fill = wr_ptr_q - rd_ptr_q;
        wready_o  = ~flush_i & (sram_fill != DepthVal);
        push      = wvalid_i & wready_o;
        rvalid_o  = (ob_count_q != 2'd0);
        rdata_o   = ob_mem_q[ob_head_q];
        pop_req   = rvalid_o & rready_i;
        pop       = pop_req & ~flush_i;
        // Only issue a read if the buffer is guaranteed room for the returning word.
        issue     = ~flush_i & (rd_ptr_q != wr_ptr_q) &
                    (({1'b0, ob_count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_req}));
        // Data returning after a flush belongs to the discarded contents.
        ob_push   = inflight_q & ~flush_i;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        ob_count_d = ob_count_q;
        ob_head_d  = ob_head_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            ob_count_d = 2'd0;
            ob_head_d  = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
            rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, issue};
            inflight_d = issue;
            ob_count_d = ob_count_q + {1'b0, ob_push} - {1'b0, pop};
            ob_head_d  = ob_head_q ^ pop;
        end
        count_d = CW'(wr_ptr_d - rd_ptr_d) + CW'(inflight_d) + CW'(ob_count_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            ob_count_q  <= 2'd0;
            ob_head_q   <= 1'b0;
            ob_mem_q[0] <= '0;
            ob_mem_q[1] <= '0;
            count_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            ob_count_q <= ob_count_d;
            ob_head_q  <= ob_head_d;
            count_q    <= count_d;
            // An in-flight read implies at most one buffered word, so the tail slot is
            // always free (or freed by a simultaneous pop of the head).
            if (ob_push) begin
                ob_mem_q[ob_head_q ^ ob_count_q[0]] <= ram_rdata0_i;
            end
        end
    end

    assign count_o      = count_q;
    assign ram_en0_o    = issue;
    assign ram_addr0_o  = rd_ptr_q[AW-1:0];
    assign ram_we0_o    = 1'b0;
    assign ram_wdata0_o = '0;
    assign ram_en1_o    = push;
    assign ram_we1_o    = push;
    assign ram_addr1_o  = wr_ptr_q[AW-1:0];
    assign ram_wdata1_o = wdata_i;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl (DATA_DEPTH=8) with a behavioural SRAM and a
// queue-based reference model of the FIFO contents.
module tb_sram_fifo_ctrl;

    localparam int DW = 32;
    localparam int DD = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [3:0]    count;
    logic          ram_en0, ram_we0, ram_en1, ram_we1;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [DW-1:0] ram_wdata0, ram_wdata1;
    logic [DW-1:0] ram_rdata0 = '0;

    logic [DW-1:0] sram [DD];

    int n_checks = 0;
    int n_errors = 0;

    // Sampled DUT outputs of the current cycle.
    logic          obs_wready, obs_rvalid;
    logic [DW-1:0] obs_rdata;
    logic [3:0]    obs_count;

    // Reference model: entries accepted and not yet popped, oldest first.
    logic [DW-1:0] q [$];

    sram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .DATA_DEPTH(DD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .wdata_i      (wdata),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .rdata_o      (rdata),
        .rvalid_o     (rvalid),
        .rready_i     (rready),
        .count_o      (count),
        .ram_en0_o    (ram_en0),
        .ram_addr0_o  (ram_addr0),
        .ram_we0_o    (ram_we0),
        .ram_wdata0_o (ram_wdata0),
        .ram_rdata0_i (ram_rdata0),
        .ram_en1_o    (ram_en1),
        .ram_addr1_o  (ram_addr1),
        .ram_we1_o    (ram_we1),
        .ram_wdata1_o (ram_wdata1)
    );

    always #5 clk = ~clk;

    // Dual-port SRAM with a registered read port.
    always @(posedge clk) begin
        if (ram_en1 && ram_we1) sram[ram_addr1] <= ram_wdata1;
        if (ram_en0) ram_rdata0 <= sram[ram_addr0];
    end

    // Drive one cycle's inputs after the falling edge and sample the outputs.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                        input logic fl);
        @(negedge clk);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        flush  = fl;
        #1;
        obs_wready = wready;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        obs_count  = count;
    endtask

    // Apply this cycle's handshakes to the reference queue.
    task automatic model_update(input logic wv, input logic [DW-1:0] wd, input logic rr,
                                input logic fl);
        if (fl) begin
            q.delete();
        end else begin
            if (obs_rvalid && rr && q.size() > 0) void'(q.pop_front());
            if (wv && obs_wready) q.push_back(wd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rvalid !== 1'b0 || count !== 4'd0 || rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: rvalid=%0b count=%0d rdata=%0h, expected 0/0/0",
                     rvalid, count, rdata);
        end
        n_checks++;
        if (ram_en0 !== 1'b0 || ram_en1 !== 1'b0 || ram_we1 !== 1'b0 || ram_we0 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ram_en: en0=%0b en1=%0b we1=%0b we0=%0b, expected all 0",
                     ram_en0, ram_en1, ram_we1, ram_we0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_wready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_wready: got %0b, expected 1", obs_wready);
        end
    endtask

    task automatic test_single();
        int exp_count [6] = '{0, 1, 1, 1, 0, 0};
        for (int k = 0; k < 6; k++) begin
            step(k == 0, (k == 0) ? 32'hA5A5_0001 : 32'h0, 1'b1, 1'b0);
            if (k == 0) begin
                n_checks++;
                if (ram_en1 !== 1'b1 || ram_we1 !== 1'b1 || ram_wdata1 !== 32'hA5A5_0001) begin
                    n_errors++;
                    $display("FAIL single_sram_write: en1=%0b we1=%0b wdata1=%0h, expected 1/1/a5a50001",
                             ram_en1, ram_we1, ram_wdata1);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (ram_en0 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL single_issue: ram_en0=%0b, expected 1", ram_en0);
                end
            end
            n_checks++;
            if (obs_rvalid !== (k == 3)) begin
                n_errors++;
                $display("FAIL single_rvalid: cycle %0d got %0b, expected %0b", k, obs_rvalid, k == 3);
            end
            if (k == 3) begin
                n_checks++;
                if (obs_rdata !== 32'hA5A5_0001) begin
                    n_errors++;
                    $display("FAIL single_rdata: got %0h, expected a5a50001", obs_rdata);
                end
            end
            n_checks++;
            if (int'(obs_count) != exp_count[k]) begin
                n_errors++;
                $display("FAIL single_count: cycle %0d got %0d, expected %0d", k, obs_count, exp_count[k]);
            end
            model_update(k == 0, 32'hA5A5_0001, 1'b1, 1'b0);
        end
    endtask

    task automatic test_fill();
        int accepted = 0;
        int popped = 0;
        int first_pop = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (obs_wready) accepted++;
            model_update(1'b1, DW'(i), 1'b0, 1'b0);
        end
        n_checks++;
        if (accepted != DD + 2) begin
            n_errors++;
            $display("FAIL fill_accepted: got %0d, expected %0d", accepted, DD + 2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_count !== 4'(DD + 2) || obs_wready !== 1'b0 || obs_rvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full_state: count=%0d wready=%0b rvalid=%0b, expected %0d/0/1",
                     obs_count, obs_wready, obs_rvalid, DD + 2);
        end
        for (int c = 0; c < 40 && popped < DD + 2; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (first_pop >= 0 && c == first_pop + 1) begin
                n_checks++;
                if (obs_wready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL fill_wready_reassert: got %0b, expected 1", obs_wready);
                end
            end
            if (obs_rvalid) begin
                if (first_pop < 0) begin
                    first_pop = c;
                    n_checks++;
                    if (obs_wready !== 1'b0) begin
                        n_errors++;
                        $display("FAIL fill_wready_before_pop: got %0b, expected 0", obs_wready);
                    end
                end
                n_checks++;
                if (obs_rdata !== DW'(popped)) begin
                    n_errors++;
                    $display("FAIL fill_pop_data: got %0h, expected %0h", obs_rdata, popped);
                end
                popped++;
            end
            model_update(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (popped != DD + 2 || obs_count !== 4'd0) begin
            n_errors++;
            $display("FAIL fill_drain: popped=%0d count=%0d, expected %0d/0", popped, obs_count, DD + 2);
        end
    endtask

    task automatic test_stream();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic wv, rr;
        logic [DW-1:0] wd;
        while (popped < 3 * DD && cyc < 500) begin
            wv = (pushed < 3 * DD) && ($urandom_range(0, 3) != 0);
            wd = $urandom;
            rr = ($urandom_range(0, 3) != 0);
            step(wv, wd, rr, 1'b0);
            n_checks++;
            if (int'(obs_count) != q.size()) begin
                n_errors++;
                $display("FAIL stream_count: cycle %0d got %0d, expected %0d", cyc, obs_count, q.size());
            end
            if (obs_rvalid && rr) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL stream_spurious_pop: got data %0h, expected no valid entry", obs_rdata);
                end else if (obs_rdata !== q[0]) begin
                    n_errors++;
                    $display("FAIL stream_data: got %0h, expected %0h", obs_rdata, q[0]);
                end
                popped++;
            end
            if (wv && obs_wready) pushed++;
            model_update(wv, wd, rr, 1'b0);
            cyc++;
        end
        n_checks++;
        if (popped != 3 * DD || q.size() != 0) begin
            n_errors++;
            $display("FAIL stream_complete: popped=%0d left=%0d, expected %0d/0", popped, q.size(), 3 * DD);
        end
    endtask

    task automatic test_flush();
        logic got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(i + 1), 1'b0, 1'b0);
            model_update(1'b1, DW'(i + 1), 1'b0, 1'b0);
        end
        // Popping the full buffer frees room and triggers a read issue this cycle.
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (ram_en0 !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_setup_issue: ram_en0=%0b, expected 1", ram_en0);
        end
        model_update(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (obs_wready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_wready: got %0b, expected 0", obs_wready);
        end
        model_update(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_rvalid !== 1'b0 || obs_count !== 4'd0) begin
            n_errors++;
            $display("FAIL flush_cleared: rvalid=%0b count=%0d, expected 0/0", obs_rvalid, obs_count);
        end
        step(1'b1, 32'h55, 1'b1, 1'b0);
        model_update(1'b1, 32'h55, 1'b1, 1'b0);
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (obs_rvalid) begin
                got = 1'b1;
                n_checks++;
                if (obs_rdata !== 32'h55) begin
                    n_errors++;
                    $display("FAIL flush_first_pop: got %0h, expected 55", obs_rdata);
                end
            end
            model_update(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL flush_first_pop_timeout: rvalid never rose, expected a pop within 10 cycles");
        end
    endtask

    task automatic test_back_to_back();
        logic got = 1'b0;
        step(1'b1, 32'hB0, 1'b0, 1'b0);
        model_update(1'b1, 32'hB0, 1'b0, 1'b0);
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            got = obs_rvalid;
            model_update(1'b0, '0, 1'b0, 1'b0);
        end
        n_checks++;
        if (!got || obs_count !== 4'd1) begin
            n_errors++;
            $display("FAIL b2b_prime: rvalid=%0b count=%0d, expected 1/1", got, obs_count);
        end
        step(1'b1, 32'hB1, 1'b1, 1'b0);
        n_checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hB0) begin
            n_errors++;
            $display("FAIL b2b_pop_data: rvalid=%0b rdata=%0h, expected 1/b0", obs_rvalid, obs_rdata);
        end
        model_update(1'b1, 32'hB1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_count !== 4'd1) begin
            n_errors++;
            $display("FAIL b2b_count_hold: got %0d, expected 1", obs_count);
        end
        model_update(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        model_update(1'b0, '0, 1'b0, 1'b1);
        // Continuous push and pop: after the 3-cycle latency there must be no bubble.
        for (int k = 0; k < 30; k++) begin
            step(1'b1, DW'(k + 32'h100), 1'b1, 1'b0);
            n_checks++;
            if (obs_rvalid !== (k >= 3)) begin
                n_errors++;
                $display("FAIL b2b_throughput_rvalid: cycle %0d got %0b, expected %0b", k, obs_rvalid, k >= 3);
            end
            if (obs_rvalid && q.size() > 0) begin
                n_checks++;
                if (obs_rdata !== q[0]) begin
                    n_errors++;
                    $display("FAIL b2b_throughput_data: got %0h, expected %0h", obs_rdata, q[0]);
                end
            end
            model_update(1'b1, DW'(k + 32'h100), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        model_update(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
            model_update(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (int'(obs_count) != q.size() || q.size() != 5) begin
            n_errors++;
            $display("FAIL areset_held: got %0d, expected 5", obs_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rvalid !== 1'b0 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL areset_immediate: rvalid=%0b count=%0d, expected 0/0", rvalid, count);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_wready !== 1'b1 || obs_rvalid !== 1'b0 || obs_count !== 4'd0) begin
            n_errors++;
            $display("FAIL areset_release: wready=%0b rvalid=%0b count=%0d, expected 1/0/0",
                     obs_wready, obs_rvalid, obs_count);
        end
        step(1'b1, 32'h77, 1'b1, 1'b0);
        model_update(1'b1, 32'h77, 1'b1, 1'b0);
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (obs_rvalid) begin
                got = 1'b1;
                n_checks++;
                if (obs_rdata !== 32'h77) begin
                    n_errors++;
                    $display("FAIL areset_first_pop: got %0h, expected 77", obs_rdata);
                end
            end
            model_update(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL areset_pop_timeout: rvalid never rose, expected a pop within 10 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives a dual-port SRAM instance: port 1 is write-only (push side), port 0 is read-only (pop side).
- The SRAM instance must be configured with BYTE_SIZE = DATA_WIDTH, so each write enable is 1 bit.
- Owns the pointers, the full/empty logic and a 2-entry output buffer. The buffer hides the SRAM's 1-cycle registered read latency and sustains 1 pop per cycle.
- Used for deep queues (refill/store buffers) where flop FIFOs are too costly.

Parameters:
- DATA_WIDTH, 32, entry width in bits.
- DATA_DEPTH, 1024, number of SRAM entries; must be a power of two and at least 2.
- AW, $clog2(DATA_DEPTH), SRAM address width (derived).

Ports:
- clk  in  1  single clock; drives both SRAM ports.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all contents.
- wdata_i  in  DATA_WIDTH  push data.
- wvalid_i  in  1  push request.
- wready_o  out  1  push accepted when wvalid_i & wready_o.
- rdata_o  out  DATA_WIDTH  head entry.
- rvalid_o  out  1  head valid.
- rready_i  in  1  pop when rvalid_o & rready_i.
- count_o  out  $clog2(DATA_DEPTH+3)  total entries held.
- ram_en0_o  out  1  SRAM port 0 enable (read).
- ram_addr0_o  out  AW  SRAM port 0 address.
- ram_we0_o  out  1  tied 0.
- ram_wdata0_o  out  DATA_WIDTH  tied 0.
- ram_rdata0_i  in  DATA_WIDTH  SRAM port 0 data; valid the cycle after ram_en0_o.
- ram_en1_o  out  1  SRAM port 1 enable (write).
- ram_addr1_o  out  AW  SRAM port 1 address.
- ram_we1_o  out  1  SRAM port 1 write enable.
- ram_wdata1_o  out  DATA_WIDTH  SRAM port 1 write data.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0 (AW+1 bits incl. wrap bit), inflight=0, ob_count=0.
  - Reset outputs: rvalid_o=0, count_o=0, wready_o=1 after deassert, rdata_o=0, all ram_* enables 0.
- Push side:
  - wready_o = ~flush_i & (wr_ptr - rd_ptr != DATA_DEPTH).
  - On push: ram_en1_o=ram_we1_o=1, ram_addr1_o=wr_ptr[AW-1:0], ram_wdata1_o=wdata_i, all combinational in the push cycle. wr_ptr increments at the clock edge.
- Read issue (combinational):
  - issue = ~flush_i & (rd_ptr != wr_ptr) & (ob_count + inflight - pop < 2), where pop = rvalid_o & rready_i.
  - ram_en0_o=issue, ram_addr0_o=rd_ptr[AW-1:0]; rd_ptr increments and inflight<=issue at the edge.
  - Registered pointers guarantee a slot is never read in the cycle it is written. Same-address read/write collision therefore cannot occur.
- Return: when inflight=1, ram_rdata0_i is written into the output buffer at the edge.
- Output buffer: 2-entry FIFO; rdata_o/rvalid_o come from its head, registered. Simultaneous return and pop is legal in any state.
- Push-to-rvalid_o latency on an empty FIFO: push in cycle 0, read issue in cycle 1, SRAM data in cycle 2, rvalid_o=1 in cycle 3.
- Throughput: 1 push and 1 pop per cycle sustained once primed.
- count_o = (wr_ptr - rd_ptr) + inflight + ob_count, registered; maximum is DATA_DEPTH+2.
- Pointer wrap: the low AW bits index the SRAM; the MSB toggles on wrap. Full = equal low bits with differing MSB; empty = pointers equal.
- flush_i (takes priority over push, pop and issue in that cycle):
  - At the edge: pointers=0, ob_count=0, inflight=0.
  - Any SRAM data returning the next cycle is discarded.
  - Cycle after flush: rvalid_o=0, count_o=0.
- Reset mid-operation: everything cleared asynchronously. SRAM contents are not cleared and are never exposed, because the pointers are reset.

Test Plan:
- Single entry: push 0xA5A5_0001 at cycle 0 on an empty FIFO with rready_i=1 -> rvalid_o=1, rdata_o=0xA5A5_0001 in cycle 3 only; count_o 0→1→…→0.
- Fill (DATA_DEPTH=8, rready_i=0): push 0..11 -> wready_o drops after 10 accepted (8 in SRAM + 2 buffered), count_o=10; then pop all -> data 0..9 in order, wready_o reasserts after the first pop frees an SRAM slot.
- Streaming: continuous push and pop for 3×DATA_DEPTH entries with random rready_i backpressure -> in-order data, no loss or duplication across pointer wrap, 1 pop/cycle when rready_i=1.
- Flush with a read inflight: push 4 entries, assert flush_i in the cycle after an issue -> next cycle rvalid_o=0, count_o=0; then push 0x55 -> first pop returns 0x55.
- Simultaneous push and pop at count_o=1 -> count_o stays 1; full-throughput pattern shows no bubble.
- Async reset mid-stream with 5 entries held -> rvalid_o=0 and count_o=0 immediately, wready_o=1 after release.
